// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the word-addressed instruction
// memory, and registers the returned instruction into IF/ID for decode.
// Handles stall, redirect, and a sticky fault on misaligned or out-of-range
// fetch addresses that freezes the stage until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  // First byte address past the end of instruction memory.
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH) << 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // What the datapath does on the coming edge; resolved once by priority.
  typedef enum logic [2:0] {
    ACT_HOLD      = 3'd0,
    ACT_FAULT_TGT = 3'd1,
    ACT_REDIRECT  = 3'd2,
    ACT_FAULT_SEQ = 3'd3,
    ACT_FETCH     = 3'd4
  } action_t;

  state_t      state;
  state_t      state_next;
  action_t     action;
  logic [31:0] pc_q;
  logic        target_bad;
  logic        pc_run_off;

  // The fetch address is the registered PC, so it has no path from inputs.
  assign imem_addr = pc_q;

  assign target_bad = (pc_target[1:0] != 2'b00) || (pc_target >= PC_LIMIT);
  assign pc_run_off = (pc_q >= PC_LIMIT);

  // State register: BOOT on reset, then advance to the computed next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      // NOTE: every clocked register uses <= so all flops sample the same
      // pre-edge values; a blocking = here would create ordering races.
      state <= state_next;
    end
  end

  // Next-state logic: BOOT is a single cycle, any fault in RUN parks in HALT.
  always_comb begin
    // NOTE: the default assignment first guarantees state_next is driven on
    // every path, so no latch is inferred.
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     if (action == ACT_FAULT_TGT || action == ACT_FAULT_SEQ) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // Action decode: only RUN acts on inputs; redirect beats stall, stall beats
  // the sequential range check, and a normal fetch is the fallback.
  always_comb begin
    action = ACT_HOLD;
    if (state == RUN) begin
      if (pc_src && target_bad)  action = ACT_FAULT_TGT;
      else if (pc_src)           action = ACT_REDIRECT;
      else if (stall)            action = ACT_HOLD;
      else if (pc_run_off)       action = ACT_FAULT_SEQ;
      else                       action = ACT_FETCH;
    end
  end

  // PC, IF/ID pipeline register, fault capture and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
      fault          <= 1'b0;
      fault_pc       <= '0;
      fetch_count    <= '0;
    end else begin
      unique case (action)
        ACT_FAULT_TGT: begin
          fault          <= 1'b1;
          fault_pc       <= pc_target;
          if_id_instr    <= NOP_INSTR;
          if_id_pc       <= '0;
          if_id_pc_plus4 <= '0;
          if_id_valid    <= 1'b0;
        end
        ACT_REDIRECT: begin
          // The instruction fetched this cycle is wrong-path: flush to a bubble.
          pc_q           <= pc_target;
          if_id_instr    <= NOP_INSTR;
          if_id_pc       <= '0;
          if_id_pc_plus4 <= '0;
          if_id_valid    <= 1'b0;
        end
        ACT_FAULT_SEQ: begin
          fault          <= 1'b1;
          fault_pc       <= pc_q;
          if_id_instr    <= NOP_INSTR;
          if_id_pc       <= '0;
          if_id_pc_plus4 <= '0;
          if_id_valid    <= 1'b0;
        end
        ACT_FETCH: begin
          if_id_instr    <= imem_rdata;
          if_id_pc       <= pc_q;
          if_id_pc_plus4 <= pc_q + 32'd4;
          if_id_valid    <= 1'b1;
          pc_q           <= pc_q + 32'd4;
          fetch_count    <= fetch_count + 32'd1;
        end
        default: begin
          // Hold: BOOT, HALT, or a stalled RUN cycle keeps everything.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios for each feature
// plus a randomized run compared cycle-by-cycle against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned LIMIT = 64 * 4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  int total;
  int bad;

  // Behavioural model of the stage's architectural state.
  typedef enum int {M_BOOT, M_RUN, M_HALT} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fpc, m_count;
  logic        m_valid, m_fault;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(64),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .pc_src        (pc_src),
    .pc_target     (pc_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .fault         (fault),
    .fault_pc      (fault_pc),
    .fetch_count   (fetch_count)
  );

  // Asynchronous word-addressed instruction memory.
  assign imem_rdata = mem[imem_addr[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = M_BOOT;
    m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_fpc = 32'h0; m_count = 32'h0;
  endtask

  task automatic model_bubble();
    m_instr = NOP; m_ipc = 32'h0; m_ipc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock of the stage, written from the fetch rules directly.
  task automatic model_clock(input logic s, input logic r, input logic [31:0] t);
    if (m_phase == M_BOOT) begin
      m_phase = M_RUN;
    end else if (m_phase == M_RUN) begin
      if (r && ((t % 4) != 0 || t >= LIMIT)) begin
        m_fault = 1'b1; m_fpc = t; m_phase = M_HALT; model_bubble();
      end else if (r) begin
        m_pc = t; model_bubble();
      end else if (s) begin
        // held
      end else if (m_pc >= LIMIT) begin
        m_fault = 1'b1; m_fpc = m_pc; m_phase = M_HALT; model_bubble();
      end else begin
        m_instr = mem[m_pc / 4]; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1'b1;
        m_pc = m_pc + 4; m_count = m_count + 1;
      end
    end
  endtask

  // Reset pulse between edges; the next rising edge is the BOOT cycle.
  task automatic do_reset();
    @(negedge clk);
    stall = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill_sequential();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h11;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h expected %h", imem_addr, 32'h0); end
    total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, NOP); end
    total++; if ({if_id_pc, if_id_pc_plus4} !== 64'h0) begin bad++; $display("FAIL reset_pcs: got %h/%h expected 0/0", if_id_pc, if_id_pc_plus4); end
    total++; if ({if_id_valid, fault} !== 2'b00) begin bad++; $display("FAIL reset_flags: got valid=%b fault=%b expected 0/0", if_id_valid, fault); end
    total++; if ({fault_pc, fetch_count} !== 64'h0) begin bad++; $display("FAIL reset_fault_count: got %h/%h expected 0/0", fault_pc, fetch_count); end
    rst = 1'b0;
    // BOOT must ignore an active redirect.
    pc_src = 1'b1; pc_target = 32'h40;
    step();
    pc_src = 1'b0;
    total++; if ({imem_addr, if_id_valid} !== {32'h0, 1'b0}) begin bad++; $display("FAIL boot_hold: got addr=%h valid=%b expected 0/0", imem_addr, if_id_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
    fill_sequential();
    do_reset();
    step();
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL seq_boot_valid: got %b expected 0", if_id_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if ({if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid} !== {exp_w[k], 32'(4 * k), 32'(4 * k + 4), 1'b1}) begin
        bad++;
        $display("FAIL seq_fetch%0d: got instr=%h pc=%h pc4=%h v=%b expected instr=%h pc=%h", k, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, exp_w[k], 32'(4 * k));
      end
    end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
  endtask

  task automatic test_stall();
    fill_sequential();
    do_reset();
    step(); step(); step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ({imem_addr, if_id_instr, fetch_count} !== {32'h8, 32'h22, 32'd2}) begin
        bad++;
        $display("FAIL stall_hold%0d: got addr=%h instr=%h count=%0d expected 8/22/2", k, imem_addr, if_id_instr, fetch_count);
      end
    end
    stall = 1'b0;
    step();
    total++; if ({if_id_instr, if_id_pc} !== {32'h33, 32'h8}) begin bad++; $display("FAIL stall_release: got instr=%h pc=%h expected 33/8", if_id_instr, if_id_pc); end
  endtask

  task automatic test_redirect();
    fill_sequential();
    do_reset();
    step(); step();
    pc_src = 1'b1; pc_target = 32'h20; stall = 1'b1;
    step();
    pc_src = 1'b0; stall = 1'b0;
    total++;
    if ({imem_addr, if_id_instr, if_id_valid, fetch_count} !== {32'h20, NOP, 1'b0, 32'd1}) begin
      bad++;
      $display("FAIL redirect_bubble: got addr=%h instr=%h v=%b count=%0d expected 20/13/0/1", imem_addr, if_id_instr, if_id_valid, fetch_count);
    end
    step();
    total++;
    if ({if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid} !== {mem[8], 32'h20, 32'h24, 1'b1}) begin
      bad++;
      $display("FAIL redirect_target: got instr=%h pc=%h pc4=%h v=%b expected %h/20/24/1", if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, mem[8]);
    end
  endtask

  task automatic test_fault_target();
    fill_sequential();
    do_reset();
    step(); step();
    pc_src = 1'b1; pc_target = 32'h22;
    step();
    pc_src = 1'b0;
    total++;
    if ({fault, fault_pc, imem_addr, if_id_valid} !== {1'b1, 32'h22, 32'h4, 1'b0}) begin
      bad++;
      $display("FAIL fault_tgt: got fault=%b fpc=%h addr=%h v=%b expected 1/22/4/0", fault, fault_pc, imem_addr, if_id_valid);
    end
    for (int k = 0; k < 6; k++) begin
      stall = 1'($urandom_range(0, 1)); pc_src = 1'($urandom_range(0, 1));
      pc_target = 32'($urandom_range(0, 63)) * 4;
      step();
      total++;
      if ({fault, fault_pc, imem_addr, if_id_valid, fetch_count} !== {1'b1, 32'h22, 32'h4, 1'b0, 32'd1}) begin
        bad++;
        $display("FAIL halt_frozen%0d: got fault=%b fpc=%h addr=%h v=%b count=%0d", k, fault, fault_pc, imem_addr, if_id_valid, fetch_count);
      end
    end
    stall = 1'b0; pc_src = 1'b0;
    do_reset();
    #1;
    total++; if ({fault, imem_addr} !== {1'b0, 32'h0}) begin bad++; $display("FAIL fault_clear: got fault=%b addr=%h expected 0/0", fault, imem_addr); end
  endtask

  task automatic test_runoff();
    fill_sequential();
    do_reset();
    step();
    pc_src = 1'b1; pc_target = 32'hF8;
    step();
    pc_src = 1'b0;
    step();
    total++; if ({if_id_instr, if_id_pc, if_id_valid} !== {mem[62], 32'hF8, 1'b1}) begin bad++; $display("FAIL runoff_f8: got instr=%h pc=%h v=%b expected %h/f8/1", if_id_instr, if_id_pc, if_id_valid, mem[62]); end
    step();
    total++; if ({if_id_instr, if_id_pc, imem_addr} !== {mem[63], 32'hFC, 32'h100}) begin bad++; $display("FAIL runoff_fc: got instr=%h pc=%h addr=%h expected %h/fc/100", if_id_instr, if_id_pc, imem_addr, mem[63]); end
    step();
    total++; if ({fault, fault_pc, if_id_valid} !== {1'b1, 32'h100, 1'b0}) begin bad++; $display("FAIL runoff_fault: got fault=%b fpc=%h v=%b expected 1/100/0", fault, fault_pc, if_id_valid); end
  endtask

  task automatic test_async_reset();
    fill_sequential();
    do_reset();
    step(); step(); step(); step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({imem_addr, if_id_valid, if_id_instr, fetch_count, fault} !== {32'h0, 1'b0, NOP, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got addr=%h v=%b instr=%h count=%0d fault=%b expected 0/0/13/0/0", imem_addr, if_id_valid, if_id_instr, fetch_count, fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int halted_for;
    logic        s, r;
    logic [31:0] t;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    do_reset();
    halted_for = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s = ($urandom_range(0, 99) < 25);
      r = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 9))
        0:       t = $urandom;
        1:       t = 32'($urandom_range(0, 255));
        2:       t = LIMIT;
        default: t = 32'($urandom_range(0, 63)) * 4;
      endcase
      stall = s; pc_src = r; pc_target = t;
      model_clock(s, r, t);
      step();
      total++;
      if ({imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fault, fault_pc, fetch_count} !==
          {m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_fault, m_fpc, m_count}) begin
        bad++;
        $display("FAIL random_cyc%0d: got addr=%h instr=%h pc=%h pc4=%h v=%b f=%b fpc=%h cnt=%0d expected addr=%h instr=%h pc=%h pc4=%h v=%b f=%b fpc=%h cnt=%0d",
                 cyc, imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fault, fault_pc, fetch_count,
                 m_pc, m_instr, m_ipc, m_ipc4, m_valid, m_fault, m_fpc, m_count);
      end
      halted_for = (m_phase == M_HALT) ? halted_for + 1 : 0;
      if (halted_for > 3) begin
        do_reset();
        halted_for = 0;
      end
    end
    stall = 1'b0; pc_src = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; stall = 1'b0; pc_src = 1'b0; pc_target = 32'h0;
    fill_sequential();
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_fault_target();
    test_runoff();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
